// File: rtl/cin_fifo.sv
// User-input port: synchronised, debounced confirm button pushing switch values into a FIFO
// that the control unit drains over the shared tri-state bus. Optional macro: CIN_SIGN_EXT_EN.
module cin_fifo #(
  parameter int BUS_W           = 32,
  parameter int VALUE_W         = 16,
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [VALUE_W-1:0]         value,
  input  logic                       user_confirm,
  input  logic                       cin_get,
  input  logic                       cin_write,
  inout  wire  [BUS_W-1:0]           bus,
  output logic                       cin_done,
  output logic                       need_input,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clear_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_meta, sync_q;
  logic [DW-1:0] deb_cnt;
  logic          deb_q, deb_prev;
  logic          press;

  logic [BUS_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [BUS_W-1:0] wr_data, rd_word;
  logic             pop, push_ok, drop, drive;

  // Input path: deb_q is registered, so an event is seen one cycle after the counter saturates.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      deb_cnt   <= '0;
      deb_q     <= 1'b0;
      deb_prev  <= 1'b0;
    end else begin
      sync_meta <= user_confirm;
      sync_q    <= sync_meta;
      if (!sync_q)
        deb_cnt <= '0;
      else if (deb_cnt != DW'(DEBOUNCE_CYCLES))
        deb_cnt <= deb_cnt + 1'b1;
      deb_q    <= (deb_cnt == DW'(DEBOUNCE_CYCLES));
      deb_prev <= deb_q;
    end
  end

  assign press = deb_q & ~deb_prev;

`ifdef CIN_SIGN_EXT_EN
  assign wr_data = BUS_W'($signed(value));
`else
  assign wr_data = BUS_W'(value);
`endif

  // Handshake: cin_get is a level request, cin_done acknowledges it while data is available;
  // cin_write grants the bus for one cycle and a word is consumed at that edge only if non-empty.
  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign cin_done   = cin_get & ~empty;
  assign need_input = cin_get & empty;

  assign pop     = cin_write & ~empty;
  assign push_ok = press & (~full | pop);
  assign drop    = press & full & ~pop;

  assign drive   = cin_write & reset_n;
  assign rd_word = empty ? '0 : mem[rd_ptr];
  assign bus     = drive ? rd_word : {BUS_W{1'bz}};

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;
    end
  end

endmodule
